// File: rtl/gpio_serial_loader.sv
// Serial-chain master for the GPIO pad control chain: shifts the pad configuration out MSB first,
// captures the returning chain data, then strobes serial_load to apply the new configuration.
module gpio_serial_loader #(
  parameter int NUM_PADS      = 9,
  parameter int PAD_CTRL_BITS = 12,
  parameter int CLK_DIV       = 2
) (
  input  logic                              mclk,
  input  logic                              resetn,
  input  logic                              cfg_start,
  input  logic [NUM_PADS*PAD_CTRL_BITS-1:0] cfg_data,
  output logic                              cfg_busy,
  output logic                              cfg_done,
  output logic [NUM_PADS*PAD_CTRL_BITS-1:0] rd_data,
  output logic                              serial_clock,
  output logic                              serial_load,
  output logic                              serial_data,
  input  logic                              serial_data_ret
);

  localparam int TOT = NUM_PADS * PAD_CTRL_BITS;
  localparam int HW  = $clog2(CLK_DIV + 1);
  localparam int BW  = $clog2(TOT + 1);
  localparam logic [HW-1:0] H_LAST = HW'(CLK_DIV - 1);
  localparam logic [BW-1:0] B_LAST = BW'(TOT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [HW-1:0]   hcnt_q, hcnt_d;
  logic            hi_q, hi_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic [TOT-1:0]  shadow_q, shadow_d;
  logic [TOT-1:0]  rd_q, rd_d;
  logic            sclk_q, sclk_d;
  logic            sload_q, sload_d;
  logic            sdata_q, sdata_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            half_end;

  // Next-state and next-output decode; outputs are registered from the next state.
  always_comb begin
    state_d  = state_q;
    hcnt_d   = hcnt_q;
    hi_d     = hi_q;
    bcnt_d   = bcnt_q;
    shadow_d = shadow_q;
    rd_d     = rd_q;
    half_end = (hcnt_q == H_LAST);

    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          shadow_d = cfg_data;
          state_d  = SHIFT;
          hcnt_d   = '0;
          hi_d     = 1'b0;
          bcnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (!half_end) begin
          hcnt_d = hcnt_q + HW'(1);
        end else if (!hi_q) begin
          // Last low cycle of a bit: the chain output still holds the pre-shift bit.
          hcnt_d = '0;
          hi_d   = 1'b1;
          rd_d   = {rd_q[TOT-2:0], serial_data_ret};
        end else begin
          hcnt_d   = '0;
          hi_d     = 1'b0;
          bcnt_d   = bcnt_q + BW'(1);
          shadow_d = {shadow_q[TOT-2:0], 1'b0};
          if (bcnt_q == B_LAST) begin
            state_d = LOAD;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      LOAD: begin
        if (!half_end) begin
          hcnt_d = hcnt_q + HW'(1);
        end else begin
          hcnt_d  = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (!half_end) begin
          hcnt_d = hcnt_q + HW'(1);
        end else begin
          hcnt_d  = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    sclk_d  = (state_d == SHIFT) && hi_d;
    sdata_d = (state_d == SHIFT) ? shadow_d[TOT-1] : 1'b0;
    sload_d = (state_d == LOAD);
    busy_d  = (state_d != IDLE);
    done_d  = (state_q == GAP) && (state_d == IDLE);
  end

  // State, counters and registered outputs with synchronous active-low reset.
  always_ff @(posedge mclk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      hcnt_q   <= '0;
      hi_q     <= 1'b0;
      bcnt_q   <= '0;
      shadow_q <= '0;
      rd_q     <= '0;
      sclk_q   <= 1'b0;
      sload_q  <= 1'b0;
      sdata_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
      hi_q     <= hi_d;
      bcnt_q   <= bcnt_d;
      shadow_q <= shadow_d;
      rd_q     <= rd_d;
      sclk_q   <= sclk_d;
      sload_q  <= sload_d;
      sdata_q  <= sdata_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign cfg_busy     = busy_q;
  assign cfg_done     = done_q;
  assign rd_data      = rd_q;
  assign serial_clock = sclk_q;
  assign serial_load  = sload_q;
  assign serial_data  = sdata_q;

endmodule
